// File: rtl/sram_like_pkg.sv
// sram_like_pkg: size encodings, illegal-access data pattern and legality check shared by the responder
package sram_like_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2, SZ_ILL = 2'd3} size_e;
  localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;
  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] lsb);
    return size == SZ_BYTE || (size == SZ_HALF && !lsb[0]) || (size == SZ_WORD && lsb == 2'b00);
  endfunction
endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: in-order response queue whose entries each count down their own latency
module resp_fifo #(
  parameter int DEPTH = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic [2:0]    push_cd,
  output logic          space,
  output logic          ok,
  output logic [DW-1:0] head_data
);
  localparam int PW = $clog2(DEPTH);
  logic [DW-1:0] dat [DEPTH];
  logic [2:0]    cd  [DEPTH];
  logic [PW-1:0] rp, wp;
  logic [PW:0]   count;
  assign ok = !rst && count != '0 && cd[rp] == 3'd0;
  assign space = count < (PW+1)'(DEPTH) || ok;
  assign head_data = dat[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (|cd[i]) cd[i] <= cd[i] - 3'd1;
      if (push) begin
        dat[wp] <= push_data;
        cd[wp] <= push_cd;
        wp <= wp + 1'b1;
      end
      if (ok) rp <= rp + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(ok);
    end
  end
endmodule

// File: rtl/sram_like_responder.sv
// sram_like_responder: SRAM-style slave with per-request latency, bounded outstanding requests and illegal-access counting
module sram_like_responder
  import sram_like_pkg::*;
#(
  parameter int MEM_AW = 10,
  parameter int MAX_OUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  input  logic [2:0]  lat_cfg,
  input  logic        stall,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [15:0] err_cnt
);
  logic [31:0] mem [2**MEM_AW];
  logic [MEM_AW-1:0] idx;
  logic legal, space, ok;
  logic [31:0] head, rd;
  logic [2:0] cd;
  logic unused_addr_bits;
  assign idx = data_addr[MEM_AW+1:2];
  assign unused_addr_bits = ^data_addr[31:MEM_AW+2];
  assign legal = is_legal(data_size, data_addr[1:0]);
  assign data_addr_ok = data_req && !stall && !rst && space;
  // read data is taken before this edge's write; a same-address write cannot coexist with a read in one cycle
  assign rd = !legal ? DEAD_BEEF : data_wr ? 32'd0 : mem[idx];
  assign cd = lat_cfg == 3'd0 ? 3'd0 : lat_cfg - 3'd1;
  assign data_data_ok = ok;
  assign data_rdata = ok ? head : 32'd0;
  always_ff @(posedge clk) begin
    if (data_addr_ok && data_wr && legal)
      for (int b = 0; b < 4; b++)
        if (data_wstrb[b]) mem[idx][8*b +: 8] <= data_wdata[8*b +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) err_cnt <= '0;
    else if (data_addr_ok && !legal && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  end
  resp_fifo #(.DEPTH(MAX_OUT), .DW(32)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(data_addr_ok),
    .push_data(rd),
    .push_cd(cd),
    .space(space),
    .ok(ok),
    .head_data(head)
  );
endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: directed steps with hand-computed expectations for the responder
module tb_sram_like_responder;
  logic clk = 1'b0, rst = 1'b1;
  logic data_req = 1'b0, data_wr = 1'b0, stall = 1'b0;
  logic [1:0] data_size = 2'd0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic [3:0] data_wstrb = '0;
  logic [2:0] lat_cfg = 3'd1;
  logic [31:0] data_rdata;
  logic data_addr_ok, data_data_ok;
  logic [15:0] err_cnt;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  sram_like_responder #(.MEM_AW(10), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb), .lat_cfg(lat_cfg),
    .stall(stall), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .err_cnt(err_cnt)
  );
  task automatic next();
    @(posedge clk);
    #1;
  endtask
  task automatic samp();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic req(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] st, input logic [2:0] lat);
    data_req = 1'b1; data_wr = wr; data_size = sz; data_addr = a;
    data_wdata = wd; data_wstrb = st; lat_cfg = lat;
  endtask
  task automatic ok_rd(input string tag, input logic ok, input logic [31:0] rd);
    chk({tag, "_ok"}, 32'(data_data_ok), 32'(ok));
    chk({tag, "_rdata"}, data_rdata, rd);
  endtask
  initial begin
    next(); next();
    data_req = 1'b1;
    samp();
    chk("rst_addr_ok", 32'(data_addr_ok), 0);
    ok_rd("rst", 1'b0, 32'h0);
    chk("rst_err", 32'(err_cnt), 0);
    next(); rst = 1'b0; data_req = 1'b0;
    // word write then read of the same word
    next(); req(1'b1, 2'd2, 32'h40, 32'h1234_5678, 4'hF, 3'd1);
    samp(); chk("w40_acc", 32'(data_addr_ok), 1);
    next(); req(1'b0, 2'd2, 32'h40, 32'h0, 4'h0, 3'd3);
    samp(); chk("r40_acc", 32'(data_addr_ok), 1); ok_rd("w40_resp", 1'b1, 32'h0);
    next(); data_req = 1'b0;
    samp(); ok_rd("r40_t2", 1'b0, 32'h0);
    next(); samp(); ok_rd("r40_t3", 1'b0, 32'h0);
    next(); samp(); ok_rd("r40_t4", 1'b1, 32'h1234_5678);
    // byte write into lane 2
    next(); req(1'b1, 2'd0, 32'h42, 32'h00AB_0000, 4'b0100, 3'd1);
    samp(); chk("bw_acc", 32'(data_addr_ok), 1);
    next(); req(1'b0, 2'd2, 32'h40, 32'h0, 4'h0, 3'd1);
    samp(); ok_rd("bw_resp", 1'b1, 32'h0);
    next(); data_req = 1'b0;
    samp(); ok_rd("bw_read", 1'b1, 32'h12AB_5678);
    // four outstanding, fifth held until the head pops
    next(); req(1'b0, 2'd2, 32'h40, 32'h0, 4'h0, 3'd5);
    samp(); chk("q0_acc", 32'(data_addr_ok), 1); ok_rd("q_t0", 1'b0, 32'h0);
    next(); req(1'b1, 2'd2, 32'h44, 32'hCAFE_F00D, 4'hF, 3'd1);
    samp(); chk("q1_acc", 32'(data_addr_ok), 1); ok_rd("q_t1", 1'b0, 32'h0);
    next(); req(1'b0, 2'd2, 32'h44, 32'h0, 4'h0, 3'd1);
    samp(); chk("q2_acc", 32'(data_addr_ok), 1); ok_rd("q_t2", 1'b0, 32'h0);
    next(); req(1'b0, 2'd2, 32'h40, 32'h0, 4'h0, 3'd1);
    samp(); chk("q3_acc", 32'(data_addr_ok), 1); ok_rd("q_t3", 1'b0, 32'h0);
    next(); req(1'b0, 2'd2, 32'h44, 32'h0, 4'h0, 3'd1);
    samp(); chk("q4_full", 32'(data_addr_ok), 0); ok_rd("q_t4", 1'b0, 32'h0);
    next(); samp(); chk("q4_acc", 32'(data_addr_ok), 1); ok_rd("q_t5", 1'b1, 32'h12AB_5678);
    next(); data_req = 1'b0;
    samp(); ok_rd("q_t6", 1'b1, 32'h0);
    next(); samp(); ok_rd("q_t7", 1'b1, 32'hCAFE_F00D);
    next(); samp(); ok_rd("q_t8", 1'b1, 32'h12AB_5678);
    next(); samp(); ok_rd("q_t9", 1'b1, 32'hCAFE_F00D);
    next(); samp(); ok_rd("q_t10", 1'b0, 32'h0);
    // misaligned word read and size-3 write are both errors
    next(); req(1'b0, 2'd2, 32'h42, 32'h0, 4'h0, 3'd1);
    samp(); chk("ill0_acc", 32'(data_addr_ok), 1);
    next(); req(1'b1, 2'd3, 32'h40, 32'hFFFF_FFFF, 4'hF, 3'd1);
    samp(); chk("ill1_acc", 32'(data_addr_ok), 1); ok_rd("ill0_resp", 1'b1, 32'hDEAD_BEEF);
    next(); req(1'b0, 2'd2, 32'h40, 32'h0, 4'h0, 3'd1);
    samp(); ok_rd("ill1_resp", 1'b1, 32'hDEAD_BEEF); chk("err2", 32'(err_cnt), 2);
    next(); data_req = 1'b0;
    samp(); ok_rd("ill_mem", 1'b1, 32'h12AB_5678);
    // reset with three responses in flight
    next(); req(1'b0, 2'd2, 32'h44, 32'h0, 4'h0, 3'd7);
    next(); next();
    samp(); chk("fl_acc", 32'(data_addr_ok), 1);
    next(); rst = 1'b1; data_req = 1'b1;
    samp(); chk("fl_rst_acc", 32'(data_addr_ok), 0); ok_rd("fl_rst", 1'b0, 32'h0);
    next(); rst = 1'b0; data_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      samp(); ok_rd("fl_drop", 1'b0, 32'h0);
      next();
    end
    chk("fl_err", 32'(err_cnt), 0);
    req(1'b0, 2'd2, 32'h44, 32'h0, 4'h0, 3'd1);
    samp(); chk("fl_post_acc", 32'(data_addr_ok), 1);
    next(); data_req = 1'b0;
    samp(); ok_rd("fl_post", 1'b1, 32'hCAFE_F00D);
    // stall backpressure
    next(); stall = 1'b1; req(1'b0, 2'd2, 32'h40, 32'h0, 4'h0, 3'd1);
    for (int i = 0; i < 10; i++) begin
      samp(); chk("stall_acc", 32'(data_addr_ok), 0); ok_rd("stall", 1'b0, 32'h0);
      next();
    end
    stall = 1'b0;
    samp(); chk("unstall_acc", 32'(data_addr_ok), 1);
    next(); data_req = 1'b0;
    samp(); ok_rd("unstall", 1'b1, 32'h12AB_5678);
    next(); samp(); ok_rd("idle", 1'b0, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
